// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file writeback path.
// Imported by the arbiter and the writeback scheduler.
package regfile_pkg;

  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int DW   = 16;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with one-hot grant.
// On contention the requester opposite the last winner is granted.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_e last;

  // Grant selection; nothing is granted while in reset.
  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      gnt = 2'b00;
    end else if (req[REQ_ALU] && req[REQ_MEM]) begin
      gnt = (last == REQ_ALU) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  // Remember the winner; hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= REQ_ALU;
    end else if (gnt[REQ_MEM]) begin
      last <= REQ_MEM;
    end else if (gnt[REQ_ALU]) begin
      last <= REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register file write port scheduler with pending-write scoreboard.
// Issue stalls on RAW/WAW; writebacks commit one cycle after grant.
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_dst,
  input  logic [AW-1:0]   issue_src_a,
  input  logic [AW-1:0]   issue_src_b,
  output logic            issue_ready,
  input  logic            alu_wb_valid,
  input  logic [AW-1:0]   alu_wb_addr,
  input  logic [DW-1:0]   alu_wb_data,
  output logic            alu_wb_ready,
  input  logic            mem_wb_valid,
  input  logic [AW-1:0]   mem_wb_addr,
  input  logic [DW-1:0]   mem_wb_data,
  output logic            mem_wb_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic [NREG-1:0] busy_mask,
  output logic            wb_err
);

  logic [1:0]      gnt;
  logic            hazard;
  logic            accept;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] busy_next;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({mem_wb_valid, alu_wb_valid}),
    .gnt (gnt)
  );

  assign alu_wb_ready = gnt[REQ_ALU];
  assign mem_wb_ready = gnt[REQ_MEM];

  // Issue hazard check against the scoreboard.
  always_comb begin
    hazard = busy_mask[issue_src_a]
           | busy_mask[issue_src_b]
           | busy_mask[issue_dst];
    issue_ready = !hazard && !rst;
    accept = issue_valid && issue_ready;
  end

  // Scoreboard update: commit clears, issue sets, set wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (accept) set_mask = NREG'(1) << issue_dst;
    if (rf_we)  clr_mask = NREG'(1) << rf_waddr;
    busy_next = (busy_mask & ~clr_mask) | set_mask;
  end

  // Scoreboard and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_mask <= '0;
      wb_err    <= 1'b0;
    end else begin
      busy_mask <= busy_next;
      if (rf_we && !busy_mask[rf_waddr]) wb_err <= 1'b1;
    end
  end

  // Registered write port driven by the granted source.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= |gnt;
      if (gnt[REQ_ALU]) begin
        rf_waddr <= alu_wb_addr;
        rf_wdata <= alu_wb_data;
      end else if (gnt[REQ_MEM]) begin
        rf_waddr <= mem_wb_addr;
        rf_wdata <= mem_wb_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler.
// Inputs change 1ns after each rising edge and are checked 1ns later.
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic [AW-1:0]   issue_dst, issue_src_a, issue_src_b;
  logic            issue_ready;
  logic            alu_wb_valid;
  logic [AW-1:0]   alu_wb_addr;
  logic [DW-1:0]   alu_wb_data;
  logic            alu_wb_ready;
  logic            mem_wb_valid;
  logic [AW-1:0]   mem_wb_addr;
  logic [DW-1:0]   mem_wb_data;
  logic            mem_wb_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [NREG-1:0] busy_mask;
  logic            wb_err;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_dst    (issue_dst),
    .issue_src_a  (issue_src_a),
    .issue_src_b  (issue_src_b),
    .issue_ready  (issue_ready),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_addr  (alu_wb_addr),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (alu_wb_ready),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_addr  (mem_wb_addr),
    .mem_wb_data  (mem_wb_data),
    .mem_wb_ready (mem_wb_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .busy_mask    (busy_mask),
    .wb_err       (wb_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] d,
                       input logic [AW-1:0] a, input logic [AW-1:0] b);
    issue_valid = v;
    issue_dst   = d;
    issue_src_a = a;
    issue_src_b = b;
  endtask

  task automatic alu(input logic v, input logic [AW-1:0] ad,
                     input logic [DW-1:0] dt);
    alu_wb_valid = v;
    alu_wb_addr  = ad;
    alu_wb_data  = dt;
  endtask

  task automatic mem(input logic v, input logic [AW-1:0] ad,
                     input logic [DW-1:0] dt);
    mem_wb_valid = v;
    mem_wb_addr  = ad;
    mem_wb_data  = dt;
  endtask

  initial begin
    rst = 1'b1;
    issue(0, 0, 0, 0);
    alu(0, 0, 0);
    mem(0, 0, 0);
    tick;
    #1 chk("rst_issue_ready", 32'(issue_ready), 0);
    tick;
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_mask), 0);
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_waddr", 32'(rf_waddr), 0);
    chk("rst_wdata", 32'(rf_wdata), 0);
    chk("rst_err", 32'(wb_err), 0);

    // RAW: issue r3, then a reader of r3 stalls until commit clears
    issue(1, 3, 1, 2);
    #1 chk("i3_ready", 32'(issue_ready), 1);
    tick;
    issue(1, 6, 3, 0);
    #1;
    chk("i3_busy", 32'(busy_mask), 32'h0008);
    chk("raw_stall0", 32'(issue_ready), 0);
    alu(1, 3, 16'h3333);
    #1 chk("g3_ready", 32'(alu_wb_ready), 1);
    tick;
    alu(0, 0, 0);
    #1;
    chk("g3_we", 32'(rf_we), 1);
    chk("g3_waddr", 32'(rf_waddr), 3);
    chk("raw_stall1", 32'(issue_ready), 0);
    tick;
    chk("g3_busy_clr", 32'(busy_mask), 0);
    chk("raw_go", 32'(issue_ready), 1);
    chk("g3_we_off", 32'(rf_we), 0);
    issue(0, 0, 0, 0);

    // ALU writeback latency
    issue(1, 5, 0, 0);
    tick;
    issue(0, 0, 0, 0);
    alu(1, 5, 16'hBEEF);
    #1;
    chk("g5_alu_ready", 32'(alu_wb_ready), 1);
    chk("g5_mem_ready", 32'(mem_wb_ready), 0);
    tick;
    alu(0, 0, 0);
    #1;
    chk("g5_we", 32'(rf_we), 1);
    chk("g5_waddr", 32'(rf_waddr), 5);
    chk("g5_wdata", 32'(rf_wdata), 32'hBEEF);
    chk("g5_busy", 32'(busy_mask), 32'h0020);
    tick;
    chk("g5_busy_clr", 32'(busy_mask), 0);

    // Commit to non-busy register sets sticky error
    mem(1, 7, 16'h0042);
    #1 chk("g7_mem_ready", 32'(mem_wb_ready), 1);
    tick;
    mem(0, 0, 0);
    #1;
    chk("g7_we", 32'(rf_we), 1);
    chk("g7_waddr", 32'(rf_waddr), 7);
    chk("g7_wdata", 32'(rf_wdata), 32'h0042);
    chk("g7_err_pre", 32'(wb_err), 0);
    tick;
    chk("g7_err", 32'(wb_err), 1);
    chk("g7_busy", 32'(busy_mask), 0);
    tick;
    chk("g7_err_sticky", 32'(wb_err), 1);

    // Contention after a MEM grant: ALU first, then MEM
    issue(1, 1, 0, 0);
    tick;
    issue(1, 2, 0, 0);
    #1 chk("i2_ready", 32'(issue_ready), 1);
    tick;
    issue(0, 0, 0, 0);
    #1 chk("i12_busy", 32'(busy_mask), 32'h0006);
    alu(1, 1, 16'h1111);
    mem(1, 2, 16'h2222);
    #1;
    chk("rr0_alu", 32'(alu_wb_ready), 1);
    chk("rr0_mem", 32'(mem_wb_ready), 0);
    tick;
    chk("rr1_alu", 32'(alu_wb_ready), 0);
    chk("rr1_mem", 32'(mem_wb_ready), 1);
    chk("rr1_we", 32'(rf_we), 1);
    chk("rr1_waddr", 32'(rf_waddr), 1);
    chk("rr1_wdata", 32'(rf_wdata), 32'h1111);
    tick;
    alu(0, 0, 0);
    mem(0, 0, 0);
    #1;
    chk("rr2_we", 32'(rf_we), 1);
    chk("rr2_waddr", 32'(rf_waddr), 2);
    chk("rr2_wdata", 32'(rf_wdata), 32'h2222);
    tick;
    chk("rr_busy_clr", 32'(busy_mask), 0);

    // Reset with a write in flight
    issue(1, 9, 0, 0);
    tick;
    issue(0, 0, 0, 0);
    alu(1, 9, 16'h9999);
    #1 chk("g9_ready", 32'(alu_wb_ready), 1);
    tick;
    alu(0, 0, 0);
    rst = 1'b1;
    mem(1, 8, 16'h0808);
    #1;
    chk("rst_mem_ready", 32'(mem_wb_ready), 0);
    chk("rst_issue_rdy", 32'(issue_ready), 0);
    tick;
    rst = 1'b0;
    mem(0, 0, 0);
    #1;
    chk("rst2_we", 32'(rf_we), 0);
    chk("rst2_busy", 32'(busy_mask), 0);
    chk("rst2_err", 32'(wb_err), 0);
    alu(1, 10, 16'h000A);
    mem(1, 11, 16'h000B);
    #1;
    chk("rst2_ptr_mem", 32'(mem_wb_ready), 1);
    chk("rst2_ptr_alu", 32'(alu_wb_ready), 0);
    tick;
    alu(0, 0, 0);
    mem(0, 0, 0);
    tick;
    tick;

    // WAW: second issue to r4 waits for its commit
    issue(1, 4, 0, 0);
    tick;
    #1;
    chk("waw_stall0", 32'(issue_ready), 0);
    alu(1, 4, 16'h4444);
    #1 chk("g4_ready", 32'(alu_wb_ready), 1);
    tick;
    alu(0, 0, 0);
    #1 chk("waw_stall1", 32'(issue_ready), 0);
    tick;
    chk("waw_go", 32'(issue_ready), 1);
    tick;
    issue(0, 0, 0, 0);
    #1 chk("waw_busy", 32'(busy_mask), 32'h0010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
Controls the single write port of the 16x16 register file. It arbitrates round-robin between two writeback sources, the ALU and the memory unit, using a valid/ready handshake, and drives the register file write enable, address and data from registered outputs. It also keeps a 16-bit scoreboard of pending destinations, so issue stalls on read-after-write (RAW) and write-after-write (WAW) hazards. No forwarding is needed.

Parameters:
NREG, 16, number of architectural registers
AW, 4, register address width (log2 NREG)
DW, 16, data width

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
issue_valid  in  1  decode presents an instruction
issue_dst  in  AW  destination register
issue_src_a  in  AW  source A register
issue_src_b  in  AW  source B register
issue_ready  out  DW-independent 1  instruction accepted this cycle (combinational)
alu_wb_valid  in  1  ALU writeback request
alu_wb_addr  in  AW  ALU writeback destination
alu_wb_data  in  DW  ALU writeback data
alu_wb_ready  out  1  ALU request granted this cycle (combinational)
mem_wb_valid  in  1  memory writeback request
mem_wb_addr  in  AW  memory writeback destination
mem_wb_data  in  DW  memory writeback data
mem_wb_ready  out  1  memory request granted this cycle (combinational)
rf_we  out  1  register file write enable (registered)
rf_waddr  out  AW  register file write address (registered)
rf_wdata  out  DW  register file write data (registered)
busy_mask  out  NREG  scoreboard; bit i set means register i has a write pending
wb_err  out  1  sticky flag: writeback to a non-busy register

Behaviour:
- Reset (rst=1 at an edge): busy_mask=0, rf_we=0, rf_waddr=0, rf_wdata=0, wb_err=0, RR pointer=ALU.
  - Reset wins over every other event in the same cycle.
  - In-flight writebacks are discarded.
  - The ready outputs are 0 during the rst cycle.
- Issue:
  - hazard = busy[src_a] | busy[src_b] | busy[dst].
  - issue_ready = !hazard && !rst; it is independent of issue_valid.
  - Accept = issue_valid && issue_ready. On accept, busy[dst] is set at the next edge.
- Writeback arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester opposite the RR pointer's last grant wins.
  - The pointer records the winner on every grant.
  - The pointer holds when there is no grant.
  - Requesters hold valid, addr and data stable until ready. Ready=1 completes the transfer in the same cycle.
- Latency:
  - Grant in cycle t loads rf_we=1, rf_waddr and rf_wdata at the end of t.
  - The register file writes at the end of t+1.
  - busy[addr] clears at the end of t+1.
  - In cycle t+2 reads see the new data and busy=0.
  - rf_we=0 in any cycle following a no-grant cycle.
- Throughput: one grant per cycle; back-to-back grants are allowed.
- Set/clear collision on the same bit: cannot occur, because hazard blocks issue to a busy dst. If it occurs anyway, set wins.
- Clear at end of t+1 and issue accept in the same cycle on different bits: both apply.
- Commit to a register whose busy bit is 0: the write still happens, busy stays 0, and wb_err sets to 1 until rst.
- Register 0 is an ordinary register (no hardwired zero).

Decomposition:
- Shared package regfile_pkg holds:
  - constants NREG, AW, DW
  - requester index enum {REQ_ALU=0, REQ_MEM=1}
- Natural sub-module: rr_arbiter2.
  - Two requests, one-hot grant output.
  - Internal last-grant pointer.
  - Synchronous reset to REQ_ALU.
- Scoreboard, issue check and output registers stay in the top module.

Test Plan:
- Reset, then issue dst=3 src=1,2 → issue_ready=1, busy_mask=0x0008 next cycle. Then issue src_a=3 → issue_ready=0 until 2 cycles after the r3 grant.
- Issue dst=5, then alu_wb r5=0xBEEF at cycle t → alu_wb_ready=1 at t; rf_we=1, rf_waddr=5, rf_wdata=0xBEEF at t+1; busy[5]=0 at t+2.
- Both valid continuously: alu r1=0x1111 and mem r2=0x2222, both pending → grants ALU at t, MEM at t+1; rf_we high 2 consecutive cycles in that order.
- mem_wb r7=0x0042 with busy[7]=0 → write occurs, wb_err=1 and stays 1, busy_mask unchanged.
- Issue dst=9, grant ALU r9, assert rst in cycle t+1 → after that edge rf_we=0, busy_mask=0, wb_err=0, pointer=ALU.
- WAW: busy[4]=1, issue dst=4 src=0,0 → issue_ready=0; after r4 commit clears, same issue accepted and busy[4] set again.
